// File: rtl/time_param_store.sv
// ---------------------------------------------------------------------------
// time_param_store
//
// Programmable store for the four alarm timing parameters (arm delay, driver
// door delay, passenger door delay, siren on-time). User write requests come
// from debounced switches, are validated, and are held back while the alarm
// is locked. A registered read port serves the alarm FSM and timer.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   reprogram  in   debounced level, rising edge requests a write
//   sel        in   [1:0] entry index for the write (0 arm .. 3 alarm_on)
//   value      in   [3:0] new value, legal range 1..15
//   defaults   in   debounced level, rising edge restores all defaults
//   lock       in   high while the alarm is SET/TRIGGER/ON, defers writes
//   interval   in   [1:0] read index
//   t_out      out  [3:0] registered value of entry[interval]
//   pending    out  high while a captured write waits for lock to drop
//   prog_done  out  one-cycle pulse when a write or restore commits
//   prog_err   out  one-cycle pulse when a request is rejected
// ---------------------------------------------------------------------------
module time_param_store #(
    parameter int unsigned DEF_ARM       = 6,
    parameter int unsigned DEF_DRIVER    = 8,
    parameter int unsigned DEF_PASSENGER = 14,
    parameter int unsigned DEF_ALARM_ON  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       reprogram,
    input  logic [1:0] sel,
    input  logic [3:0] value,
    input  logic       defaults,
    input  logic       lock,
    input  logic [1:0] interval,
    output logic [3:0] t_out,
    output logic       pending,
    output logic       prog_done,
    output logic       prog_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [3:0] entry [4];
    logic       reprogram_q;
    logic       defaults_q;
    logic [1:0] sel_h;
    logic [3:0] value_h;
    logic       rp_rise;
    logic       df_rise;
    logic       pending_n;
    logic       done_n;
    logic       err_n;
    logic       capture;
    logic       restore;
    logic       commit;

    assign rp_rise = reprogram & ~reprogram_q;
    assign df_rise = defaults & ~defaults_q;

    // Next-state and request decoding. Defaults beats a same-edge reprogram
    // only when it is actually accepted; a rejected (locked) restore still
    // lets the reprogram request be evaluated. COMMIT ignores all requests,
    // so a press landing there is lost and must be repeated by the user.
    always_comb begin
        state_n   = state;
        pending_n = pending;
        done_n    = 1'b0;
        err_n     = 1'b0;
        capture   = 1'b0;
        restore   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                pending_n = 1'b0;
                if (df_rise && !lock) begin
                    restore = 1'b1;
                    done_n  = 1'b1;
                end else begin
                    if (df_rise) begin
                        err_n = 1'b1;
                    end
                    if (rp_rise) begin
                        if (value == 4'd0) begin
                            err_n = 1'b1;
                        end else begin
                            capture = 1'b1;
                            if (lock) begin
                                state_n   = PENDING;
                                pending_n = 1'b1;
                            end else begin
                                state_n = COMMIT;
                            end
                        end
                    end
                end
            end
            PENDING: begin
                pending_n = 1'b1;
                if (rp_rise) begin
                    if (value == 4'd0) begin
                        err_n = 1'b1;
                    end else begin
                        capture = 1'b1;
                    end
                end
                if (df_rise) begin
                    err_n = 1'b1;
                end
                if (!lock) begin
                    state_n   = COMMIT;
                    pending_n = 1'b0;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                done_n    = 1'b1;
                pending_n = 1'b0;
                state_n   = IDLE;
            end
            default: begin
                state_n   = IDLE;
                pending_n = 1'b0;
            end
        endcase
    end

    // State register plus edge-detect flops and the status outputs. The
    // edge-detect flops update every cycle regardless of state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            reprogram_q <= 1'b0;
            defaults_q  <= 1'b0;
            pending     <= 1'b0;
            prog_done   <= 1'b0;
            prog_err    <= 1'b0;
        end else begin
            state       <= state_n;
            reprogram_q <= reprogram;
            defaults_q  <= defaults;
            pending     <= pending_n;
            prog_done   <= done_n;
            prog_err    <= err_n;
        end
    end

    // Captured write request; a later valid request overwrites it so the
    // last press before lock drops is the one that lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_h   <= 2'd0;
            value_h <= 4'd0;
        end else if (capture) begin
            sel_h   <= sel;
            value_h <= value;
        end
    end

    // Parameter storage. Restore and commit come from different states and
    // can never coincide.
    always_ff @(posedge clock) begin
        if (reset || restore) begin
            entry[0] <= 4'(DEF_ARM);
            entry[1] <= 4'(DEF_DRIVER);
            entry[2] <= 4'(DEF_PASSENGER);
            entry[3] <= 4'(DEF_ALARM_ON);
        end else if (commit) begin
            entry[sel_h] <= value_h;
        end
    end

    // Registered read port: the value written on an edge shows up on t_out
    // one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            t_out <= 4'(DEF_ARM);
        end else begin
            t_out <= entry[interval];
        end
    end

endmodule

// File: tb/tb_time_param_store.sv
// ---------------------------------------------------------------------------
// tb_time_param_store
//
// Self-checking bench for time_param_store. A table of directed vectors
// covers reset reads, an unlocked write, locked deferral with last-wins,
// and rejects; hand-written sequences cover held reprogram, defaults
// priority and reset during a pending write.
// ---------------------------------------------------------------------------
module tb_time_param_store;

    logic       clock;
    logic       reset;
    logic       reprogram;
    logic [1:0] sel;
    logic [3:0] value;
    logic       defaults;
    logic       lock;
    logic [1:0] interval;
    logic [3:0] t_out;
    logic       pending;
    logic       prog_done;
    logic       prog_err;

    int checks;
    int errors;

    typedef struct {
        logic       rp;
        logic [1:0] sl;
        logic [3:0] vl;
        logic       df;
        logic       lk;
        logic [1:0] iv;
        logic [3:0] exp_t;
        logic       exp_p;
        logic       exp_d;
        logic       exp_e;
    } vec_t;

    vec_t vecs [21];

    time_param_store dut (
        .clock     (clock),
        .reset     (reset),
        .reprogram (reprogram),
        .sel       (sel),
        .value     (value),
        .defaults  (defaults),
        .lock      (lock),
        .interval  (interval),
        .t_out     (t_out),
        .pending   (pending),
        .prog_done (prog_done),
        .prog_err  (prog_err)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rp, input logic [1:0] sl,
                                input logic [3:0] vl, input logic df,
                                input logic lk, input logic [1:0] iv,
                                input logic [3:0] et, input logic ep,
                                input logic ed, input logic ee);
        vec_t v;
        v.rp = rp; v.sl = sl; v.vl = vl; v.df = df; v.lk = lk; v.iv = iv;
        v.exp_t = et; v.exp_p = ep; v.exp_d = ed; v.exp_e = ee;
        return v;
    endfunction

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        reprogram = v.rp;
        sel       = v.sl;
        value     = v.vl;
        defaults  = v.df;
        lock      = v.lk;
        interval  = v.iv;
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] et,
                               input logic ep, input logic ed, input logic ee);
        checkValue({name, ".t_out"},     int'(t_out),     int'(et));
        checkValue({name, ".pending"},   int'(pending),   int'(ep));
        checkValue({name, ".prog_done"}, int'(prog_done), int'(ed));
        checkValue({name, ".prog_err"},  int'(prog_err),  int'(ee));
    endtask

    task automatic writeEntry(input logic [1:0] s, input logic [3:0] v);
        lock = 1'b0; sel = s; value = v; reprogram = 1'b1;
        tick();
        reprogram = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int done_cnt;
        int err_cnt;
        checks = 0;
        errors = 0;

        // Each vector: inputs applied before the edge, outputs expected after.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0,  6, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1,  8, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 2, 14, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 3, 10, 0, 0, 0);
        vecs[4]  = mk(1, 2, 5, 0, 0, 2, 14, 0, 0, 0);
        vecs[5]  = mk(1, 2, 5, 0, 0, 2, 14, 0, 1, 0);
        vecs[6]  = mk(0, 2, 5, 0, 0, 2,  5, 0, 0, 0);
        vecs[7]  = mk(1, 1, 3, 0, 1, 1,  8, 1, 0, 0);
        vecs[8]  = mk(0, 1, 3, 0, 1, 1,  8, 1, 0, 0);
        vecs[9]  = mk(1, 1, 9, 0, 1, 1,  8, 1, 0, 0);
        vecs[10] = mk(0, 1, 9, 0, 1, 1,  8, 1, 0, 0);
        vecs[11] = mk(0, 1, 9, 0, 0, 1,  8, 0, 0, 0);
        vecs[12] = mk(0, 1, 9, 0, 0, 1,  8, 0, 1, 0);
        vecs[13] = mk(0, 1, 9, 0, 0, 1,  9, 0, 0, 0);
        vecs[14] = mk(1, 2, 0, 0, 0, 2,  5, 0, 0, 1);
        vecs[15] = mk(0, 2, 0, 0, 0, 2,  5, 0, 0, 0);
        vecs[16] = mk(0, 2, 0, 1, 1, 2,  5, 0, 0, 1);
        vecs[17] = mk(0, 2, 0, 0, 1, 2,  5, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0,  6, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 1,  9, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 3, 10, 0, 0, 0);

        reset = 1'b1; reprogram = 1'b0; sel = 2'd0; value = 4'd0;
        defaults = 1'b0; lock = 1'b0; interval = 2'd0;
        tick();
        tick();
        checkOutput("reset", 4'd6, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_t, vecs[i].exp_p,
                        vecs[i].exp_d, vecs[i].exp_e);
        end

        $display("[TB] reprogram held high for 20 cycles");
        lock = 1'b0; sel = 2'd3; value = 4'd12; interval = 2'd3;
        reprogram = 1'b1;
        done_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            done_cnt += int'(prog_done);
            err_cnt  += int'(prog_err);
        end
        reprogram = 1'b0;
        tick();
        checkValue("hold.done_count", done_cnt, 1);
        checkValue("hold.err_count", err_cnt, 0);
        checkValue("hold.t_out", int'(t_out), 12);

        $display("[TB] defaults priority over reprogram");
        writeEntry(2'd0, 4'd1);
        writeEntry(2'd1, 4'd2);
        writeEntry(2'd2, 4'd3);
        writeEntry(2'd3, 4'd4);
        for (int k = 0; k < 4; k++) begin
            interval = 2'(k);
            tick();
            checkValue($sformatf("prog.entry%0d", k), int'(t_out), k + 1);
        end
        lock = 1'b0; sel = 2'd0; value = 4'd7;
        defaults = 1'b1; reprogram = 1'b1;
        done_cnt = 0;
        tick();
        checkValue("dflt.first_done", int'(prog_done), 1);
        done_cnt += int'(prog_done);
        for (int i = 0; i < 3; i++) begin
            tick();
            done_cnt += int'(prog_done);
        end
        defaults = 1'b0; reprogram = 1'b0;
        checkValue("dflt.done_count", done_cnt, 1);
        begin
            int exp_def [4];
            exp_def = '{6, 8, 14, 10};
            for (int k = 0; k < 4; k++) begin
                interval = 2'(k);
                tick();
                checkValue($sformatf("dflt.entry%0d", k), int'(t_out), exp_def[k]);
            end
        end

        $display("[TB] reset during pending write");
        interval = 2'd3; lock = 1'b1; sel = 2'd3; value = 4'd2;
        reprogram = 1'b1;
        tick();
        checkValue("rst.pending_before", int'(pending), 1);
        reprogram = 1'b0;
        reset = 1'b1;
        tick();
        checkOutput("rst.during", 4'd6, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        lock = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            done_cnt += int'(prog_done);
        end
        checkValue("rst.done_count", done_cnt, 0);
        checkOutput("rst.after", 4'd10, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_param_store.md
Name: time_param_store

Overview:
Programmable store for the four alarm timing parameters: arm delay, driver delay, passenger delay and alarm-on time. It is the writer side of the timing-parameter interface. It accepts user reprogram requests from the debounced switches, validates them, and defers them while the alarm is armed. It serves a registered read port to the alarm FSM and timer, replacing the fixed reset-loaded delay registers.

Parameters:
- DEF_ARM, 6: reset/default value of entry 0 (arm delay, seconds).
- DEF_DRIVER, 8: default value of entry 1 (driver door delay).
- DEF_PASSENGER, 14: default value of entry 2 (passenger door delay).
- DEF_ALARM_ON, 10: default value of entry 3 (siren on-time).

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- reprogram, input, 1: debounced level; a rising edge requests a write.
- sel, input, 2: entry index for the write (0 arm, 1 driver, 2 passenger, 3 alarm_on).
- value, input, 4: new value, legal range 1..15.
- defaults, input, 1: debounced level; a rising edge requests a restore of all four defaults.
- lock, input, 1: high while the alarm is SET/TRIGGER/ON; writes are deferred.
- interval, input, 2: read index.
- t_out, output, 4: registered value of the entry selected by interval.
- pending, output, 1: high while a captured write is waiting for lock to drop.
- prog_done, output, 1: one-cycle pulse when a write or restore commits.
- prog_err, output, 1: one-cycle pulse when a request is rejected.

Behaviour:
- Reset (synchronous, active-high):
  - Entries 0..3 load DEF_ARM, DEF_DRIVER, DEF_PASSENGER, DEF_ALARM_ON.
  - t_out = DEF_ARM; pending = 0; prog_done = 0; prog_err = 0.
  - FSM goes to IDLE; edge-detect flops, sel_h and value_h clear to 0.
  - reset in any state discards a pending or committing write.
- Edge detection: rp_rise = reprogram & ~reprogram_q; df_rise = defaults & ~defaults_q. Both _q flops are updated every cycle.
- Read port: t_out <= entry[interval] on every cycle, so latency is 1 cycle.
  - On the edge where an entry is written, t_out still shows the old value.
  - The new value appears on t_out one cycle after the write edge.
- prog_done and prog_err default to 0 each cycle. They are asserted only as described below.
- FSM states: IDLE, PENDING, COMMIT.
- IDLE:
  - df_rise & ~lock: restore all four defaults this edge, prog_done <= 1, stay IDLE. A simultaneous rp_rise is dropped (defaults has priority).
  - df_rise & lock: prog_err <= 1, no change, stay IDLE. A simultaneous rp_rise is still evaluated as below.
  - rp_rise & value == 0: prog_err <= 1, stay IDLE.
  - rp_rise & value != 0: capture sel_h <= sel and value_h <= value. If lock is high, go to PENDING and set pending <= 1; otherwise go to COMMIT.
- PENDING:
  - pending = 1.
  - A new rp_rise with value != 0 overwrites sel_h and value_h (last request wins).
  - A new rp_rise with value == 0 gives prog_err <= 1 and keeps the old capture.
  - df_rise gives prog_err <= 1 and the pending write is kept.
  - When lock = 0 (sampled that edge), go to COMMIT and set pending <= 0. A same-edge rp_rise still updates the capture first.
- COMMIT (exactly one cycle):
  - entry[sel_h] <= value_h, prog_done <= 1, go to IDLE.
  - rp_rise or df_rise arriving in this cycle is ignored. The _q flops still update, so the user must release and press again.
- Timing for an unlocked write:
  - reprogram sampled high at edge N (low at N-1) → COMMIT state after N.
  - Write and prog_done = 1 after edge N+1.
  - t_out shows the new value after edge N+2, if interval == sel.
- Width rules:
  - All entries are 4 bits unsigned; 0 is never stored.
  - Defaults above 15 are illegal parameter values. Behaviour is undefined; the bench does not test them.
- The lock level only defers writes. Reads are never blocked.

Test Plan:
1. Reset then read: assert reset 2 cycles, sweep interval 0..3 → t_out = 6, 8, 14, 10, each one cycle after interval changes; pending, prog_done and prog_err = 0.
2. Unlocked write: lock = 0, sel = 2, value = 5, raise reprogram at edge N → prog_done = 1 for exactly one cycle after N+1; with interval = 2, t_out = 14 until edge N+2, then 5.
3. Locked deferral and last-wins:
   - lock = 1, write sel = 1, value = 3 → pending = 1, no prog_done.
   - Then write sel = 1, value = 9 → still pending.
   - Drop lock → after two edges prog_done pulses and entry 1 = 9 (not 3); pending = 0.
4. Rejects:
   - Write value = 0 in IDLE → prog_err one-cycle pulse, entry unchanged.
   - defaults rise while lock = 1 → prog_err pulse, entries unchanged.
   - Holding reprogram high for 20 cycles → only one request.
5. Defaults priority: entries reprogrammed to 1, 2, 3, 4; lock = 0; raise defaults and reprogram (sel = 0, value = 7) on the same edge → entries return to 6, 8, 14, 10 and entry 0 ≠ 7; a single prog_done pulse.
6. Reset mid-operation: lock = 1, pending write sel = 3, value = 2; assert reset one cycle → pending = 0, entry 3 = 10; dropping lock afterwards causes no commit and no prog_done.
